// File: rtl/ltc2208_pkg.sv
// Shared LT2208 definitions: source-mode codes, PRBS taps, randomizer and LFSR step.
// Latency: n/a (constants and pure combinational functions).
// Backpressure: n/a.
package ltc2208_pkg;

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_PRBS   = 2'd2;
  localparam logic [1:0] MODE_ZERO   = 2'd3;

  // Fibonacci taps x^16+x^14+x^13+x^11+1 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // LT2208 randomizer: bit 0 is sent as-is and flips every other bit when set.
  // It is its own inverse, so the de-randomizer bench can reuse it.
  function automatic logic [15:0] lt2208_randomize(input logic [15:0] raw);
    return {raw[15:1] ^ {15{raw[0]}}, raw[0]};
  endfunction

  // One left-shift step of the PRBS generator, feedback enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO, DEPTH entries of W bits, head word visible combinationally.
// Latency: a pushed word is visible at the head one clock after the push edge.
// Backpressure: push_rdy is registered !full; a push presented while full is ignored even if popped.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q, rdy_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_rdy = rdy_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);

  // Next pointers, occupancy and ready; ready looks at the post-edge count
  always_comb begin
    push_ok  = push_vld & rdy_q;
    pop_ok   = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    rdy_d    = (count_d != CW'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
    end
  end

  // Storage array; contents are meaningless after reset because the pointers clear
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Pointers, count and ready; reset discards anything queued or arriving
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: rtl/ltc2208_emulator.sv
// LT2208 ADC bus emulator: stream/ramp/PRBS/zero source, optional randomizer, overflow flag.
// Latency: FIFO head to adc_data 1 clock; input push to earliest adc_data 2 clocks.
// Backpressure: in_ready = registered !full of the sample FIFO; adc_data never stalls.
module ltc2208_emulator
  import ltc2208_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RAMP_STEP  = 16'd1,
  parameter logic [15:0] OVF_THRESH = 16'd32767,
  parameter logic [15:0] PRBS_SEED  = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mode,
  input  logic        random,
  output logic [15:0] adc_data,
  output logic        adc_ovf,
  output logic [15:0] underrun_cnt
);

  logic [15:0]        fifo_head;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [15:0]        raw;
  logic signed [16:0] raw_s;
  logic signed [16:0] raw_neg;
  logic signed [16:0] thresh_s;
  logic               ovf;

  logic [15:0] ramp_q, ramp_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] ucnt_q, ucnt_d;
  logic [15:0] adc_data_q, adc_data_d;
  logic        adc_ovf_q, adc_ovf_d;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push_vld (in_valid),
    .push_dat (in_sample),
    .push_rdy (in_ready),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty)
  );

  // Source select; only the selected generator advances, the others hold state
  always_comb begin
    raw      = 16'h0000;
    fifo_pop = 1'b0;
    hold_d   = hold_q;
    ramp_d   = ramp_q;
    lfsr_d   = lfsr_q;
    ucnt_d   = ucnt_q;
    case (mode)
      MODE_STREAM: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          raw      = fifo_head;
          hold_d   = fifo_head;
        end else begin
          // Starved: repeat the last sample rather than glitching the bus
          raw = hold_q;
          if (ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
          end
        end
      end
      MODE_RAMP: begin
        raw    = ramp_q;
        ramp_d = ramp_q + RAMP_STEP;
      end
      MODE_PRBS: begin
        raw    = lfsr_q;
        lfsr_d = lfsr_next(lfsr_q);
      end
      default: begin
        raw = 16'h0000;
      end
    endcase
  end

  // Overflow on the raw word in 17 bits so that -(-32768) does not wrap
  always_comb begin
    raw_s     = {raw[15], raw};
    raw_neg   = -raw_s;
    thresh_s  = {1'b0, OVF_THRESH};
    ovf       = (raw == 16'h8000) | (raw_s >= thresh_s) | (raw_neg >= thresh_s);
    adc_ovf_d = ovf;
    adc_data_d = random ? lt2208_randomize(raw) : raw;
  end

  // Output register plus generator, hold and underrun state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ramp_q     <= 16'h0000;
      lfsr_q     <= PRBS_SEED;
      hold_q     <= 16'h0000;
      ucnt_q     <= 16'h0000;
      adc_data_q <= 16'h0000;
      adc_ovf_q  <= 1'b0;
    end else begin
      ramp_q     <= ramp_d;
      lfsr_q     <= lfsr_d;
      hold_q     <= hold_d;
      ucnt_q     <= ucnt_d;
      adc_data_q <= adc_data_d;
      adc_ovf_q  <= adc_ovf_d;
    end
  end

  assign adc_data     = adc_data_q;
  assign adc_ovf      = adc_ovf_q;
  assign underrun_cnt = ucnt_q;

endmodule
